aes_encrypt: RTL

AES_ENCRYPT -- requirements
Module: aes_encrypt

---
 rtl/aes_pkg.sv | 59 +++++
 rtl/aes_sbox.sv | 15 +
 rtl/aes_encrypt.sv | 132 +++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 types, FSM encoding, round constants and GF(2^8) helpers.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef logic [127:0] block_t;

  localparam int unsigned NUM_ROUNDS = 10;

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // b^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = b;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: GF(2^8) inverse followed by the FIPS-197 affine transform.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] value,
  output logic [7:0] subst
);

  logic [7:0] inv;

  assign inv   = gf_inv(value);
  assign subst = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/aes_encrypt.sv
// Iterative AES-128 encryptor, one round per cycle with on-the-fly key expansion.
// Define AES_ENCRYPT_ABORT_EN to let AES_START=0 during ROUND abandon the operation.
module aes_encrypt
  import aes_pkg::*;
(
  input  logic         CLK,
  input  logic         RESET,
  input  logic         AES_START,
  input  logic [127:0] AES_KEY,
  input  logic [127:0] AES_MSG_DEC,
  output logic         AES_DONE,
  output logic [127:0] AES_MSG_ENC
);

  state_t      state;
  state_t      state_nxt;
  block_t      st;
  block_t      rkey;
  logic [3:0]  cnt;
  logic        last_round;
  logic        advance;

  block_t      sub;
  block_t      shf;
  block_t      mix;
  block_t      rkey_nxt;
  block_t      round_out;
  logic [31:0] rot_word;
  logic [31:0] sub_word;
  logic [31:0] key_tmp;

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  assign last_round = (cnt == 4'(NUM_ROUNDS));

  for (genvar i = 0; i < 16; i++) begin : g_sub_bytes
    aes_sbox u_sbox (
      .value (st[127-8*i -: 8]),
      .subst (sub[127-8*i -: 8])
    );
  end

  // Key schedule works on RotWord of the last word of the current round key.
  assign rot_word = {rkey[23:0], rkey[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sub_word
    aes_sbox u_sbox (
      .value (rot_word[31-8*i -: 8]),
      .subst (sub_word[31-8*i -: 8])
    );
  end

  always_comb begin
    key_tmp            = sub_word ^ {rcon(cnt), 24'h000000};
    rkey_nxt[127:96]   = rkey[127:96] ^ key_tmp;
    rkey_nxt[95:64]    = rkey[95:64]  ^ rkey_nxt[127:96];
    rkey_nxt[63:32]    = rkey[63:32]  ^ rkey_nxt[95:64];
    rkey_nxt[31:0]     = rkey[31:0]   ^ rkey_nxt[63:32];
  end

  // Byte index = 4*column + row; row r rotates left by r columns.
  always_comb begin
    shf = '0;
    mix = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shf[127-8*(4*c+r) -: 8] = sub[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mix[127-32*c -: 32] = mix_col(shf[127-32*c -: 32]);
    end
  end

  assign round_out = (last_round ? shf : mix) ^ rkey_nxt;

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (AES_START) state_nxt = ROUND;
      ROUND: begin
        if (last_round) state_nxt = DONE;
`ifdef AES_ENCRYPT_ABORT_EN
        if (!AES_START) state_nxt = IDLE;
`endif
      end
      DONE:  if (!AES_START) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // An aborted round leaves ROUND for IDLE; only surviving rounds touch the datapath.
  assign advance = (state == ROUND) && (state_nxt != IDLE);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      st          <= '0;
      rkey        <= '0;
      cnt         <= 4'd0;
      AES_DONE    <= 1'b0;
      AES_MSG_ENC <= '0;
    end else begin
      AES_DONE <= (state_nxt == DONE);
      if (state == IDLE && AES_START) begin
        st   <= AES_MSG_DEC ^ AES_KEY;
        rkey <= AES_KEY;
        cnt  <= 4'd1;
      end else if (advance) begin
        st   <= round_out;
        rkey <= rkey_nxt;
        cnt  <= cnt + 4'd1;
        if (last_round) AES_MSG_ENC <= round_out;
      end
    end
  end

endmodule
